// File: rtl/axi4_mem_responder.sv
// -----------------------------------------------------------------------------
// axi4_mem_responder
//
// Synthesizable AXI4 slave memory model. It terminates one mem_N channel of
// FPGATop so that the memory traffic can be served in RTL. It serves INCR read
// and write bursts from an internal word array. The read latency is fixed by a
// parameter.
//
// Parameters
//   ID_BITS      AXI ID width
//   ADDR_BITS    byte-address width
//   DATA_BITS    data width (power of two, >= 8)
//   DEPTH_LOG2   log2 of the number of DATA_BITS words stored
//   READ_LATENCY cycles from AR acceptance to the first R beat valid (1..15)
//
// Ports
//   clock, reset_n                 clock, async active-low reset
//   ar_* / aw_*                    read / write address channels (size ignored)
//   w_*                            write data channel with byte strobes
//   r_*                            read data channel
//   b_*                            write response channel
//
// Optional feature
//   AXI4_MEM_RESPONDER_DECERR_EN   When defined, word indices at or above
//                                  2^DEPTH_LOG2 are out of range. Such reads
//                                  return 0 with DECERR. Such writes are
//                                  dropped and the burst's B carries DECERR.
//                                  When undefined, indices wrap and every
//                                  response is OKAY.
// -----------------------------------------------------------------------------
module axi4_mem_responder #(
    parameter int ID_BITS      = 4,
    parameter int ADDR_BITS    = 32,
    parameter int DATA_BITS    = 64,
    parameter int DEPTH_LOG2   = 12,
    parameter int READ_LATENCY = 2
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   ar_valid,
    output logic                   ar_ready,
    input  logic [ADDR_BITS-1:0]   ar_bits_addr,
    input  logic [ID_BITS-1:0]     ar_bits_id,
    input  logic [2:0]             ar_bits_size,
    input  logic [7:0]             ar_bits_len,
    input  logic                   aw_valid,
    output logic                   aw_ready,
    input  logic [ADDR_BITS-1:0]   aw_bits_addr,
    input  logic [ID_BITS-1:0]     aw_bits_id,
    input  logic [2:0]             aw_bits_size,
    input  logic [7:0]             aw_bits_len,
    input  logic                   w_valid,
    output logic                   w_ready,
    input  logic [DATA_BITS-1:0]   w_bits_data,
    input  logic [DATA_BITS/8-1:0] w_bits_strb,
    input  logic                   w_bits_last,
    output logic                   r_valid,
    input  logic                   r_ready,
    output logic [DATA_BITS-1:0]   r_bits_data,
    output logic [ID_BITS-1:0]     r_bits_id,
    output logic [1:0]             r_bits_resp,
    output logic                   r_bits_last,
    output logic                   b_valid,
    input  logic                   b_ready,
    output logic [ID_BITS-1:0]     b_bits_id,
    output logic [1:0]             b_bits_resp
);

    localparam int STRB_BITS = DATA_BITS / 8;
    localparam int OFFS      = $clog2(STRB_BITS);
    // One extra bit so that base + beat can never silently overflow.
    localparam int IDX_W     = ADDR_BITS + 1;
    localparam int WORDS     = 1 << DEPTH_LOG2;

    localparam logic [3:0] LAT_LOAD    = 4'(READ_LATENCY - 1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        R_IDLE = 2'b00,
        R_WAIT = 2'b01,
        R_DATA = 2'b10
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'b00,
        W_DATA = 2'b01,
        W_RESP = 2'b10
    } wr_state_t;

    logic [DATA_BITS-1:0] mem [0:WORDS-1];

    // Full-width word index of a beat: byte address to word address, plus beat.
    function automatic logic [IDX_W-1:0] word_index(input logic [ADDR_BITS-1:0] addr,
                                                    input logic [7:0]           beat);
        word_index = {1'b0, addr >> OFFS} + {{(IDX_W-8){1'b0}}, beat};
    endfunction

    // ------------------------------------------------------------------ read
    rd_state_t              rd_state_r, rd_state_s;
    logic [ADDR_BITS-1:0]   rd_addr_r;
    logic [7:0]             rd_len_r;
    logic [7:0]             rd_beat_r;
    logic [3:0]             rd_lat_r;
    logic [ID_BITS-1:0]     rd_id_r;
    logic [DATA_BITS-1:0]   r_data_r;
    logic [1:0]             r_resp_r;
    logic                   r_last_r;

    logic                   rd_hs_s;
    logic                   rd_load_s;
    logic [7:0]             rd_fetch_beat_s;
    logic [IDX_W-1:0]       rd_idx_s;
    logic                   rd_oor_s;

    assign rd_hs_s         = (rd_state_r == R_DATA) && r_ready;
    // The beat that the next load fetches. It is beat 0 when leaving R_WAIT,
    // and the following beat after each R handshake.
    assign rd_fetch_beat_s = (rd_state_r == R_DATA) ? (rd_beat_r + 8'd1) : 8'd0;
    assign rd_load_s       = ((rd_state_r == R_WAIT) && (rd_lat_r == 4'd0)) ||
                             (rd_hs_s && !r_last_r);
    assign rd_idx_s        = word_index(rd_addr_r, rd_fetch_beat_s);
`ifdef AXI4_MEM_RESPONDER_DECERR_EN
    assign rd_oor_s        = |rd_idx_s[IDX_W-1:DEPTH_LOG2];
`else
    assign rd_oor_s        = 1'b0;
`endif

    // Read FSM next-state decode.
    always_comb begin
        rd_state_s = rd_state_r;
        case (rd_state_r)
            R_IDLE: begin
                if (ar_valid) rd_state_s = R_WAIT;
                else          rd_state_s = R_IDLE;
            end
            R_WAIT: begin
                if (rd_lat_r == 4'd0) rd_state_s = R_DATA;
                else                  rd_state_s = R_WAIT;
            end
            R_DATA: begin
                if (rd_hs_s && r_last_r) rd_state_s = R_IDLE;
                else                     rd_state_s = R_DATA;
            end
            default: rd_state_s = R_IDLE;
        endcase
    end

    // Read state, burst context and the registered R payload.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_state_r <= R_IDLE;
            rd_addr_r  <= {ADDR_BITS{1'b0}};
            rd_len_r   <= 8'd0;
            rd_beat_r  <= 8'd0;
            rd_lat_r   <= 4'd0;
            rd_id_r    <= {ID_BITS{1'b0}};
            r_data_r   <= {DATA_BITS{1'b0}};
            r_resp_r   <= RESP_OKAY;
            r_last_r   <= 1'b0;
        end else begin
            rd_state_r <= rd_state_s;
            if ((rd_state_r == R_IDLE) && ar_valid) begin
                rd_addr_r <= ar_bits_addr;
                rd_len_r  <= ar_bits_len;
                rd_id_r   <= ar_bits_id;
                rd_beat_r <= 8'd0;
                rd_lat_r  <= LAT_LOAD;
            end else if ((rd_state_r == R_WAIT) && (rd_lat_r != 4'd0)) begin
                rd_lat_r <= rd_lat_r - 4'd1;
            end
            // The array is read with a non-blocking update. A write to the same
            // word on the same edge is therefore not seen: the old data is returned.
            if (rd_load_s) begin
                rd_beat_r <= rd_fetch_beat_s;
                r_last_r  <= (rd_fetch_beat_s == rd_len_r);
                if (rd_oor_s) begin
                    r_data_r <= {DATA_BITS{1'b0}};
                    r_resp_r <= RESP_DECERR;
                end else begin
                    r_data_r <= mem[rd_idx_s[DEPTH_LOG2-1:0]];
                    r_resp_r <= RESP_OKAY;
                end
            end else if (rd_hs_s) begin
                r_last_r <= 1'b0;
            end
        end
    end

    // ----------------------------------------------------------------- write
    wr_state_t              wr_state_r, wr_state_s;
    logic [ADDR_BITS-1:0]   wr_addr_r;
    logic [7:0]             wr_len_r;
    logic [7:0]             wr_beat_r;
    logic [ID_BITS-1:0]     wr_id_r;
    logic                   wr_err_r;
    logic                   b_valid_r;
    logic [1:0]             b_resp_r;

    logic                   wr_hs_s;
    logic                   wr_done_s;
    logic                   wr_we_s;
    logic [IDX_W-1:0]       wr_idx_s;
    logic                   wr_oor_s;

    assign wr_hs_s   = (wr_state_r == W_DATA) && w_valid;
    // The burst ends on whichever comes first: the beat count or w_last.
    assign wr_done_s = wr_hs_s && ((wr_beat_r == wr_len_r) || w_bits_last);
    assign wr_idx_s  = word_index(wr_addr_r, wr_beat_r);
`ifdef AXI4_MEM_RESPONDER_DECERR_EN
    assign wr_oor_s  = |wr_idx_s[IDX_W-1:DEPTH_LOG2];
`else
    assign wr_oor_s  = 1'b0;
`endif
    assign wr_we_s   = wr_hs_s && !wr_oor_s;

    // Write FSM next-state decode.
    always_comb begin
        wr_state_s = wr_state_r;
        case (wr_state_r)
            W_IDLE: begin
                if (aw_valid) wr_state_s = W_DATA;
                else          wr_state_s = W_IDLE;
            end
            W_DATA: begin
                if (wr_done_s) wr_state_s = W_RESP;
                else           wr_state_s = W_DATA;
            end
            W_RESP: begin
                if (b_valid_r && b_ready) wr_state_s = W_IDLE;
                else                      wr_state_s = W_RESP;
            end
            default: wr_state_s = W_IDLE;
        endcase
    end

    // Write state, burst context and the registered B channel.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_state_r <= W_IDLE;
            wr_addr_r  <= {ADDR_BITS{1'b0}};
            wr_len_r   <= 8'd0;
            wr_beat_r  <= 8'd0;
            wr_id_r    <= {ID_BITS{1'b0}};
            wr_err_r   <= 1'b0;
            b_valid_r  <= 1'b0;
            b_resp_r   <= RESP_OKAY;
        end else begin
            wr_state_r <= wr_state_s;
            if ((wr_state_r == W_IDLE) && aw_valid) begin
                wr_addr_r <= aw_bits_addr;
                wr_len_r  <= aw_bits_len;
                wr_id_r   <= aw_bits_id;
                wr_beat_r <= 8'd0;
                wr_err_r  <= 1'b0;
            end else if (wr_hs_s) begin
                wr_beat_r <= wr_beat_r + 8'd1;
                wr_err_r  <= wr_err_r | wr_oor_s;
            end
            if (wr_done_s) begin
                b_resp_r <= (wr_err_r | wr_oor_s) ? RESP_DECERR : RESP_OKAY;
            end
            // B becomes valid one cycle after the FSM enters W_RESP. This gives
            // the spacing of two edges between the last W and B valid.
            b_valid_r <= (wr_state_r == W_RESP) && !(b_valid_r && b_ready);
        end
    end

    // Byte-enabled array write. The array is not cleared by reset.
    always_ff @(posedge clock) begin
        if (wr_we_s) begin
            for (int i = 0; i < STRB_BITS; i++) begin
                if (w_bits_strb[i]) begin
                    mem[wr_idx_s[DEPTH_LOG2-1:0]][i*8 +: 8] <= w_bits_data[i*8 +: 8];
                end
            end
        end
    end

    // --------------------------------------------------------------- outputs
    assign ar_ready    = (rd_state_r == R_IDLE);
    assign r_valid     = (rd_state_r == R_DATA);
    assign r_bits_data = r_data_r;
    assign r_bits_id   = rd_id_r;
    assign r_bits_resp = r_resp_r;
    assign r_bits_last = r_last_r;

    assign aw_ready    = (wr_state_r == W_IDLE);
    assign w_ready     = (wr_state_r == W_DATA);
    assign b_valid     = b_valid_r;
    assign b_bits_id   = wr_id_r;
    assign b_bits_resp = b_resp_r;

    // AxSIZE is ignored because every beat is full width. The upper index bits
    // only matter when out-of-range detection is built in.
    logic unused_s;
    assign unused_s = ^{ar_bits_size, aw_bits_size,
                        rd_idx_s[IDX_W-1:DEPTH_LOG2], wr_idx_s[IDX_W-1:DEPTH_LOG2]};

endmodule

// File: tb/tb_axi4_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_axi4_mem_responder
//
// Self-checking bench for axi4_mem_responder. It uses the following stimulus:
//   - a fill of the whole array
//   - a table of directed bursts with expected responses
//   - a reset applied in the middle of a burst
//   - randomized bursts checked against a word-array reference model
// -----------------------------------------------------------------------------
module tb_axi4_mem_responder;

    localparam int READ_LATENCY = 3;
    localparam int WORDS        = 4096;

    logic        clock;
    logic        reset_n;
    logic        ar_valid, ar_ready;
    logic [31:0] ar_bits_addr;
    logic [3:0]  ar_bits_id;
    logic [2:0]  ar_bits_size;
    logic [7:0]  ar_bits_len;
    logic        aw_valid, aw_ready;
    logic [31:0] aw_bits_addr;
    logic [3:0]  aw_bits_id;
    logic [2:0]  aw_bits_size;
    logic [7:0]  aw_bits_len;
    logic        w_valid, w_ready;
    logic [63:0] w_bits_data;
    logic [7:0]  w_bits_strb;
    logic        w_bits_last;
    logic        r_valid, r_ready;
    logic [63:0] r_bits_data;
    logic [3:0]  r_bits_id;
    logic [1:0]  r_bits_resp;
    logic        r_bits_last;
    logic        b_valid, b_ready;
    logic [3:0]  b_bits_id;
    logic [1:0]  b_bits_resp;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] mdl [0:WORDS-1];

    axi4_mem_responder #(
        .ID_BITS(4), .ADDR_BITS(32), .DATA_BITS(64), .DEPTH_LOG2(12),
        .READ_LATENCY(READ_LATENCY)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_bits_addr(ar_bits_addr),
        .ar_bits_id(ar_bits_id), .ar_bits_size(ar_bits_size), .ar_bits_len(ar_bits_len),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_bits_addr(aw_bits_addr),
        .aw_bits_id(aw_bits_id), .aw_bits_size(aw_bits_size), .aw_bits_len(aw_bits_len),
        .w_valid(w_valid), .w_ready(w_ready), .w_bits_data(w_bits_data),
        .w_bits_strb(w_bits_strb), .w_bits_last(w_bits_last),
        .r_valid(r_valid), .r_ready(r_ready), .r_bits_data(r_bits_data),
        .r_bits_id(r_bits_id), .r_bits_resp(r_bits_resp), .r_bits_last(r_bits_last),
        .b_valid(b_valid), .b_ready(b_ready), .b_bits_id(b_bits_id), .b_bits_resp(b_bits_resp)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Reference: expected data/resp for beat k of a burst starting at addr.
    function automatic void exp_rd(input logic [31:0] addr, input int k,
                                   output logic [63:0] d, output logic [1:0] rsp);
        longint unsigned w;
        w = 64'(addr >> 3) + 64'(k);
`ifdef AXI4_MEM_RESPONDER_DECERR_EN
        if (w >= 64'(WORDS)) begin
            d = 64'd0; rsp = 2'b11;
        end else begin
            d = mdl[w]; rsp = 2'b00;
        end
`else
        d = mdl[w % 64'(WORDS)]; rsp = 2'b00;
`endif
    endfunction

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                            input logic [7:0] strb, input logic [63:0] d0, input int nbeats,
                            output logic [1:0] bresp_o);
        int guard;
        bit err;
        longint unsigned w;
        logic [63:0] d;
        err = 1'b0;
        aw_valid = 1'b1; aw_bits_addr = addr; aw_bits_id = id; aw_bits_len = len; aw_bits_size = 3'd3;
        guard = 0;
        while (aw_ready !== 1'b1 && guard < 50) begin step(); guard++; end
        check("aw_wait", 64'(guard < 50), 64'd1);
        step();
        aw_valid = 1'b0;
        for (int k = 0; k < nbeats; k++) begin
            if ($urandom_range(0, 3) == 0) begin w_valid = 1'b0; step(); end
            d = d0 * 64'(k + 1);
            w_valid = 1'b1; w_bits_data = d; w_bits_strb = strb; w_bits_last = (k == nbeats - 1);
            guard = 0;
            while (w_ready !== 1'b1 && guard < 50) begin step(); guard++; end
            check("w_wait", 64'(guard < 50), 64'd1);
            step();
            w = 64'(addr >> 3) + 64'(k);
`ifdef AXI4_MEM_RESPONDER_DECERR_EN
            if (w >= 64'(WORDS)) err = 1'b1;
            else for (int i = 0; i < 8; i++) if (strb[i]) mdl[w][i*8 +: 8] = d[i*8 +: 8];
`else
            for (int i = 0; i < 8; i++) if (strb[i]) mdl[w % 64'(WORDS)][i*8 +: 8] = d[i*8 +: 8];
`endif
        end
        w_valid = 1'b0; w_bits_last = 1'b0;
        check("w_ready_after_last", w_ready, 0);
        check("b_early", b_valid, 0);
        step();
        check("b_valid", b_valid, 1);
        check("b_id", b_bits_id, id);
        check("b_resp", b_bits_resp, err ? 2'b11 : 2'b00);
        bresp_o = b_bits_resp;
        repeat ($urandom_range(0, 2)) begin
            step();
            check("b_hold", {b_valid, b_bits_id}, {1'b1, id});
        end
        b_ready = 1'b1;
        step();
        b_ready = 1'b0;
        check("b_clear", b_valid, 0);
        check("aw_ready_again", aw_ready, 1);
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready
    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                           input int mode, output logic [63:0] d0_o, output logic [1:0] r0_o);
        int guard, beat, cyc;
        logic rdy;
        logic [3:0] pat;
        logic [63:0] ed;
        logic [1:0] er;
        pat = 4'b1001;
        ar_valid = 1'b1; ar_bits_addr = addr; ar_bits_id = id; ar_bits_len = len; ar_bits_size = 3'd3;
        guard = 0;
        while (ar_ready !== 1'b1 && guard < 50) begin step(); guard++; end
        check("ar_wait", 64'(guard < 50), 64'd1);
        step();
        ar_valid = 1'b0;
        for (int c = 0; c < READ_LATENCY; c++) begin
            check("r_lat_early", r_valid, 0);
            step();
        end
        check("r_lat", r_valid, 1);
        beat = 0; cyc = 0; guard = 0;
        d0_o = 64'd0; r0_o = 2'b00;
        while (beat <= int'(len) && guard < 2000) begin
            exp_rd(addr, beat, ed, er);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = pat[cyc % 4];
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            r_ready = rdy;
            check("r_valid", r_valid, 1);
            check("r_data", r_bits_data, ed);
            check("r_resp", r_bits_resp, er);
            check("r_id", r_bits_id, id);
            check("r_last", r_bits_last, (beat == int'(len)));
            if (beat == 0) begin d0_o = r_bits_data; r0_o = r_bits_resp; end
            if (rdy) beat++;
            cyc++; guard++;
            step();
        end
        r_ready = 1'b0;
        check("r_burst_done", 64'(guard < 2000), 64'd1);
        check("r_valid_after", r_valid, 0);
        check("ar_ready_again", ar_ready, 1);
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [3:0]  id;
        logic [7:0]  strb;
        logic [63:0] d0;
        int          nbeats;
        int          rmode;
        bit          chk;
        logic [63:0] exp_d0;
        logic [1:0]  exp_resp;
    } vec_t;

    initial begin
        vec_t vt [13];
        logic [63:0] got_d, ed;
        logic [1:0]  got_r, er;
        int          guard;
        logic [31:0] ra;
        logic [7:0]  rl;
        int          nb;

        vt[0]  = '{1'b1, 32'h40,   8'd3, 4'd5,  8'hFF, 64'h11, 4, 0, 1'b0, 64'h0, 2'b00};
        vt[1]  = '{1'b0, 32'h40,   8'd3, 4'd6,  8'h00, 64'h0,  0, 0, 1'b1, 64'h11, 2'b00};
        vt[2]  = '{1'b1, 32'h80,   8'd0, 4'd1,  8'hFF, 64'h0123456789ABCDEF, 1, 0, 1'b0, 64'h0, 2'b00};
        vt[3]  = '{1'b1, 32'h80,   8'd0, 4'd2,  8'h01, 64'hFF, 1, 0, 1'b0, 64'h0, 2'b00};
        vt[4]  = '{1'b0, 32'h80,   8'd0, 4'd3,  8'h00, 64'h0,  0, 0, 1'b1, 64'h0123456789ABCDFF, 2'b00};
        vt[5]  = '{1'b1, 32'h0,    8'd0, 4'd4,  8'hFF, 64'hA5A5A5A5A5A5A5A5, 1, 0, 1'b0, 64'h0, 2'b00};
`ifdef AXI4_MEM_RESPONDER_DECERR_EN
        vt[6]  = '{1'b0, 32'h8000, 8'd0, 4'd7,  8'h00, 64'h0,  0, 0, 1'b1, 64'h0, 2'b11};
        vt[7]  = '{1'b1, 32'h8000, 8'd0, 4'd8,  8'hFF, 64'h5A5A5A5A5A5A5A5A, 1, 0, 1'b0, 64'h0, 2'b11};
        vt[8]  = '{1'b0, 32'h0,    8'd0, 4'd9,  8'h00, 64'h0,  0, 0, 1'b1, 64'hA5A5A5A5A5A5A5A5, 2'b00};
`else
        vt[6]  = '{1'b0, 32'h8000, 8'd0, 4'd7,  8'h00, 64'h0,  0, 0, 1'b1, 64'hA5A5A5A5A5A5A5A5, 2'b00};
        vt[7]  = '{1'b1, 32'h8000, 8'd0, 4'd8,  8'hFF, 64'h5A5A5A5A5A5A5A5A, 1, 0, 1'b0, 64'h0, 2'b00};
        vt[8]  = '{1'b0, 32'h0,    8'd0, 4'd9,  8'h00, 64'h0,  0, 0, 1'b1, 64'h5A5A5A5A5A5A5A5A, 2'b00};
`endif
        vt[9]  = '{1'b0, 32'h200,  8'd7, 4'd10, 8'h00, 64'h0,  0, 1, 1'b0, 64'h0, 2'b00};
        vt[10] = '{1'b1, 32'h100,  8'd3, 4'd11, 8'hFF, 64'h1000, 2, 0, 1'b0, 64'h0, 2'b00};
        vt[11] = '{1'b0, 32'h100,  8'd3, 4'd12, 8'h00, 64'h0,  0, 2, 1'b1, 64'h1000, 2'b00};
        vt[12] = '{1'b0, 32'h7FF8, 8'd1, 4'd13, 8'h00, 64'h0,  0, 0, 1'b0, 64'h0, 2'b00};

        reset_n = 1'b0;
        ar_valid = 1'b0; ar_bits_addr = 32'd0; ar_bits_id = 4'd0; ar_bits_size = 3'd0; ar_bits_len = 8'd0;
        aw_valid = 1'b0; aw_bits_addr = 32'd0; aw_bits_id = 4'd0; aw_bits_size = 3'd0; aw_bits_len = 8'd0;
        w_valid = 1'b0; w_bits_data = 64'd0; w_bits_strb = 8'd0; w_bits_last = 1'b0;
        r_ready = 1'b0; b_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_ar_ready", ar_ready, 1);
        check("rst_aw_ready", aw_ready, 1);
        check("rst_w_ready", w_ready, 0);
        check("rst_r_valid", r_valid, 0);
        check("rst_r_last", r_bits_last, 0);
        check("rst_b_valid", b_valid, 0);
        check("rst_r_data", r_bits_data, 0);
        check("rst_r_id_resp", {r_bits_id, r_bits_resp}, 0);
        check("rst_b_id_resp", {b_bits_id, b_bits_resp}, 0);
        reset_n = 1'b1;
        step();

        // Fill every word so that the model is fully known.
        for (int b = 0; b < 16; b++)
            do_write(32'(b * 2048), 8'd255, 4'(b), 8'hFF, {$urandom, $urandom}, 256, got_r);

        for (int i = 0; i < 13; i++) begin
            if (vt[i].wr) begin
                do_write(vt[i].addr, vt[i].len, vt[i].id, vt[i].strb, vt[i].d0, vt[i].nbeats, got_r);
                check("vec_bresp", got_r, vt[i].exp_resp);
            end else begin
                do_read(vt[i].addr, vt[i].len, vt[i].id, vt[i].rmode, got_d, got_r);
                if (vt[i].chk) begin
                    check("vec_rdata0", got_d, vt[i].exp_d0);
                    check("vec_rresp0", got_r, vt[i].exp_resp);
                end
            end
        end

        // Reset while beat 2 of a len-7 read is presented.
        ar_valid = 1'b1; ar_bits_addr = 32'h300; ar_bits_id = 4'd3; ar_bits_len = 8'd7;
        guard = 0;
        while (ar_ready !== 1'b1 && guard < 50) begin step(); guard++; end
        step();
        ar_valid = 1'b0;
        guard = 0;
        while (r_valid !== 1'b1 && guard < 20) begin step(); guard++; end
        check("rst_seq_wait", 64'(guard < 20), 64'd1);
        r_ready = 1'b1;
        step();
        step();
        exp_rd(32'h300, 2, ed, er);
        check("rst_seq_beat2", r_bits_data, ed);
        r_ready = 1'b0;
        reset_n = 1'b0;
        #1;
        check("rst_seq_r_valid", r_valid, 0);
        check("rst_seq_ar_ready", ar_ready, 1);
        #2;
        reset_n = 1'b1;
        step();
        do_read(32'h300, 8'd7, 4'd9, 0, got_d, got_r);
        exp_rd(32'h300, 0, ed, er);
        check("post_rst_data", got_d, ed);

        // Randomized bursts against the model.
        for (int n = 0; n < 40; n++) begin
            ra = (32'($urandom_range(0, 4100)) << 3) | 32'($urandom_range(0, 7));
            rl = 8'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                nb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, int'(rl) + 1) : int'(rl) + 1;
                do_write(ra, rl, 4'($urandom), 8'($urandom), {$urandom, $urandom}, nb, got_r);
            end else begin
                do_read(ra, rl, 4'($urandom), $urandom_range(0, 2), got_d, got_r);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi4_mem_responder.md
# axi4_mem_responder

- Synthesizable AXI4 slave memory model for the simulation top-level.
- Terminates one `mem_N` channel driven by FPGATop, so a memory channel can run in RTL instead of through the host-side `tick` exchange.
- Serves INCR read and write bursts from an internal word array with a fixed, programmable read latency.
- Port names match the `mem_N_*` signal set of FPGATop, so it binds directly by channel prefix.

## Interface
Parameters:
- `ID_BITS`, default 4: AXI ID width.
- `ADDR_BITS`, default 32: byte-address width.
- `DATA_BITS`, default 64: data width; power of two, at least 8.
- `DEPTH_LOG2`, default 12: log2 of the number of `DATA_BITS` words stored.
- `READ_LATENCY`, default 2: cycles from AR acceptance to the first R beat valid; range 1..15.

Ports (`STRB_BITS` = `DATA_BITS`/8):
- `clock` input 1: sole clock; all state updates on the rising edge.
- `reset_n` input 1: reset, asynchronous and active-low. One clock; reset is asynchronous and active-low.
- `ar_valid` input 1: read address valid.
- `ar_ready` output 1: read address accepted.
- `ar_bits_addr`/`_id`/`_size`/`_len` input `ADDR_BITS`/`ID_BITS`/3/8: AR payload.
- `aw_valid` input 1: write address valid.
- `aw_ready` output 1: write address accepted.
- `aw_bits_addr`/`_id`/`_size`/`_len` input `ADDR_BITS`/`ID_BITS`/3/8: AW payload.
- `w_valid` input 1: write beat valid.
- `w_ready` output 1: write beat accepted.
- `w_bits_data`/`_strb`/`_last` input `DATA_BITS`/`STRB_BITS`/1: W payload.
- `r_valid` output 1: read beat valid.
- `r_ready` input 1: read beat consumed.
- `r_bits_data`/`_id`/`_resp`/`_last` output `DATA_BITS`/`ID_BITS`/2/1: R payload.
- `b_valid` output 1: write response valid.
- `b_ready` input 1: write response consumed.
- `b_bits_id`/`_resp` output `ID_BITS`/2: B payload.

## Operation
**Read and write paths**
- The read and write paths are independent state machines. Each has at most one burst outstanding.
- Read FSM: `R_IDLE` -> `R_WAIT` -> `R_DATA` -> `R_IDLE`.
  - `ar_ready` = 1 only in `R_IDLE`.
  - On an AR handshake, latch addr/id/len, clear the beat counter, and load the latency counter with `READ_LATENCY`-1.
  - In `R_WAIT`, go to `R_DATA` when the counter reaches 0.
  - In `R_DATA`, `r_valid` = 1. Each `r_valid`&`r_ready` advances the beat.
  - `r_bits_last` = 1 when beat == len. Return to `R_IDLE` after the last beat handshakes.
- Write FSM: `W_IDLE` -> `W_DATA` -> `W_RESP` -> `W_IDLE`.
  - `aw_ready` = 1 only in `W_IDLE`; `w_ready` = 1 only in `W_DATA`.
  - Each W handshake writes the bytes whose strobe bit is set and leaves the other bytes unchanged.
  - Leave `W_DATA` on the beat where either beat == len or `w_bits_last` = 1, whichever comes first.
  - In `W_RESP`, `b_valid` = 1 with the latched id. Return to `W_IDLE` on `b_ready`.

**Addressing**
- Word index = (addr >> log2(`STRB_BITS`)) + beat.
- `_size` is ignored; every beat is full width.
- The index is taken modulo 2^`DEPTH_LOG2` unless the error feature is enabled (see Configuration).
- Response code is OKAY (2'b00) by default.

**Collisions**
- If a read and a write touch the same word in the same cycle, the read returns the old data.

**Reset**
- Reset returns both FSMs to IDLE immediately and drops any burst in flight.
- Memory contents are not cleared.

## Timing
- Reset values: `ar_ready` = 1, `aw_ready` = 1; `w_ready`, `r_valid`, `r_bits_last`, `b_valid` = 0; all payload outputs = 0.
- All outputs are registered or decoded from FSM state only; there are no combinational paths from inputs to outputs.
- Read latency: an AR handshake at edge N puts the first beat valid after edge N+`READ_LATENCY`. Subsequent beats follow at 1 per cycle while `r_ready` = 1.
- Write response: the last W handshake at edge N gives `b_valid` = 1 after edge N+1.
- A new AR is accepted no earlier than the cycle after the last R handshake (same rule for AW after B).
- Valid and payload hold stable while ready = 0.

## Configuration
- `AXI4_MEM_RESPONDER_DECERR_EN` defined:
  - Any beat whose word index is at or above 2^`DEPTH_LOG2` is out of range.
  - Out-of-range read beats return data 0 with resp 2'b11.
  - Out-of-range write beats are dropped.
  - B resp = 2'b11 if any beat of the burst was out of range.
- `AXI4_MEM_RESPONDER_DECERR_EN` undefined: indices wrap and all responses are OKAY.

## Test plan
- Reset with `ar_valid` = 0 -> all outputs at their reset values; `ar_ready` = `aw_ready` = 1.
- AW addr 0x40, len 3, 4 beats of data 0x11..0x44 with full strobe; then AR addr 0x40, len 3 -> B id matches and resp 0; R returns 0x11, 0x22, 0x33, 0x44; `r_bits_last` only on the 4th beat; first beat valid exactly `READ_LATENCY` cycles after AR.
- Write 0xFF at 0x80 with strobe 0x01, then read 0x80 -> low byte 0xFF, other bytes unchanged.
- Read burst len 7 while `r_ready` toggles 1,0,0,1 -> no beat dropped or duplicated; payload stable while stalled.
- `reset_n` asserted during R beat 2 of len 7 -> `r_valid` = 0 immediately; the next AR is served normally.
- Address 2^`DEPTH_LOG2` × `STRB_BITS` -> with the macro: resp 2'b11, data 0. Without the macro: data of word 0, resp 0.
